// File: rtl/pair_event_window_counter.sv
// ----------------------------------------------------------------------------
// pair_event_window_counter
//
// Purpose:
//   Counts the 1-cycle "pair detected" pulses from the pair-detector stage
//   over back-to-back windows of WINDOW clocks. At the end of each window the
//   count is reported with a 1-cycle strobe. Alarm and saturation flags for
//   that window are reported alongside the count. A saturating lifetime total
//   of all pulses is kept for debug readout.
//
// Parameters:
//   WINDOW  clocks per measurement window (>= 2)
//   CNT_W   width of the window count; the count clamps at 2^CNT_W-1
//   THRESH  alarm threshold; alarm when the clamped window count >= THRESH
//   TOT_W   width of the saturating lifetime total
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = run windows back-to-back, 0 = abort and go idle
//   pair_in      in   pair pulse from the detector, sampled every edge
//   busy         out  1 while a window is in progress
//   count_out    out  count of the last completed window (held otherwise)
//   count_valid  out  1-cycle strobe: count_out/alarm/sat just updated
//   alarm        out  last completed window count >= THRESH
//   sat          out  last completed window count saturated
//   total_out    out  lifetime pair count since reset, saturating
// ----------------------------------------------------------------------------
module pair_event_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5,
  parameter int THRESH = 4,
  parameter int TOT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pair_in,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             alarm,
  output logic             sat,
  output logic [TOT_W-1:0] total_out
);

  localparam int CYC_W = $clog2(WINDOW);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Window accumulator add: clamps at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add_cnt(input logic [CNT_W-1:0] a,
                                                    input logic inc);
    if (inc && (a != CNT_MAX)) begin
      sat_add_cnt = a + CNT_W'(1);
    end else begin
      sat_add_cnt = a;
    end
  endfunction

  // Lifetime total add: clamps at the all-ones value instead of wrapping.
  function automatic logic [TOT_W-1:0] sat_add_tot(input logic [TOT_W-1:0] a,
                                                    input logic inc);
    if (inc && (a != TOT_MAX)) begin
      sat_add_tot = a + TOT_W'(1);
    end else begin
      sat_add_tot = a;
    end
  endfunction

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             alarm_q, alarm_d;
  logic             sat_q, sat_d;
  logic [TOT_W-1:0] total_q, total_d;

  logic [CNT_W-1:0] acc_next_s;
  logic             ovf_next_s;

  // Next-state logic for the window FSM, the report registers and the total.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    alarm_d = alarm_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    total_d = sat_add_tot(total_q, pair_in);

    acc_next_s = sat_add_cnt(acc_q, pair_in);
    // ovf is sticky for the window: once the count has clamped, the window
    // is reported as saturated even if the final sampled edge has no pulse.
    ovf_next_s = ovf_q | (pair_in & (acc_q == CNT_MAX));

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          // The enabling edge only arms the window; pair_in is not counted.
          state_d = S_RUN;
          cyc_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!enable) begin
          // Abort: partial window dropped, last report left untouched.
          state_d = S_IDLE;
          cyc_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end else if (cyc_q == CYC_LAST) begin
          // Window end: fold in this edge's pulse, report, restart at once.
          count_d = acc_next_s;
          sat_d   = ovf_next_s;
          alarm_d = (int'({1'b0, acc_next_s}) >= THRESH);
          valid_d = 1'b1;
          cyc_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
          acc_d = acc_next_s;
          ovf_d = ovf_next_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        acc_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      alarm_q <= 1'b0;
      sat_q   <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      valid_q <= valid_d;
      alarm_q <= alarm_d;
      sat_q   <= sat_d;
      total_q <= total_d;
    end
  end

  assign busy        = busy_q;
  assign count_out   = count_q;
  assign count_valid = valid_q;
  assign alarm       = alarm_q;
  assign sat         = sat_q;
  assign total_out   = total_q;

endmodule
